// File: rtl/phase_step_config_writer.sv
`default_nettype none
// ============================================================================
// Module   : phase_step_config_writer
// Purpose  : Buffers 16-bit phase-step writes from the host side in a small
//            in-order FIFO and drives the phase accumulation stage's
//            byte-wide config write port. Each buffered word goes out as an
//            atomic two-cycle sequence: high byte first, then low byte.
//            i_WriteHold stops new sequences from starting but never splits
//            one that has already started.
// Ports    : i_Clock, i_Reset (synchronous, active-high)
//            i_WriteValid / o_WriteReady / i_WriteAddr / i_WriteData
//                                        - host write handshake
//            i_WriteHold                 - blocks the start of new sequences
//            o_PhaseStepConfigWriteEnable - bit0 = [15:8], bit1 = [7:0]
//            o_PhaseStepConfigWriteAddr/Data - address and byte being written
//            o_Busy, o_FifoCount         - status
//            o_DropCount                 - present only with the option below
// Option   : PHASE_STEP_WRITER_DROP_COUNT_EN - ready is tied high, writes that
//            arrive while the FIFO is full are discarded and counted in
//            o_DropCount (saturating at 255).
// Revision : 1.0 - initial release
// ============================================================================
module phase_step_config_writer #(
    parameter int ADDR_WIDTH = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            i_Clock,
    input  logic                            i_Reset,
    input  logic                            i_WriteValid,
    output logic                            o_WriteReady,
    input  logic [ADDR_WIDTH-1:0]           i_WriteAddr,
    input  logic [15:0]                     i_WriteData,
    input  logic                            i_WriteHold,
    output logic [1:0]                      o_PhaseStepConfigWriteEnable,
    output logic [ADDR_WIDTH-1:0]           o_PhaseStepConfigWriteAddr,
    output logic [7:0]                      o_PhaseStepConfigWriteData,
    output logic                            o_Busy,
    output logic [$clog2(FIFO_DEPTH):0]     o_FifoCount
`ifdef PHASE_STEP_WRITER_DROP_COUNT_EN
    ,
    output logic [7:0]                      o_DropCount
`endif
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WR_HI = 2'd1,
        S_WR_LO = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;

    logic [ADDR_WIDTH-1:0]  r_fifo_addr [FIFO_DEPTH];
    logic [15:0]            r_fifo_data [FIFO_DEPTH];
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_CNT_W-1:0]     r_count;
    logic [c_CNT_W-1:0]     w_count_next;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;

    // Only the low byte must survive past the WR_HI edge; the high byte
    // and address are registered straight to the outputs on the pop.
    logic [7:0]             r_lo_byte;

    logic [1:0]             r_wr_en;
    logic [ADDR_WIDTH-1:0]  r_wr_addr;
    logic [7:0]             r_wr_data;

    // Full/empty come from the registered count only, so ready never
    // depends combinationally on i_WriteValid.
    assign w_full  = (r_count == c_DEPTH);
    assign w_empty = (r_count == '0);

    // A full FIFO never accepts, even if a pop happens on the same edge.
    assign w_push  = i_WriteValid && !w_full;

`ifdef PHASE_STEP_WRITER_DROP_COUNT_EN
    logic       w_drop;
    logic [7:0] r_drop_count;

    assign w_drop       = i_WriteValid && w_full;
    assign o_WriteReady = 1'b1;
    assign o_DropCount  = r_drop_count;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_drop_count <= 8'd0;
        end else if (w_drop && (r_drop_count != 8'hFF)) begin
            r_drop_count <= r_drop_count + 8'd1;
        end
    end
`else
    assign o_WriteReady = !w_full;
`endif

    // ------------------------------------------------------------------
    // Sequencer: next state and pop decision
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE, S_WR_LO: begin
                if (!w_empty && !i_WriteHold) begin
                    w_next_state = S_WR_HI;
                    w_pop        = 1'b1;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            // Hold is deliberately not consulted here: a started
            // sequence always completes its low byte.
            S_WR_HI: w_next_state = S_WR_LO;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // Storage is not reset; validity is tracked by the pointers and count.
    always_ff @(posedge i_Clock) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= i_WriteAddr;
            r_fifo_data[r_wr_ptr] <= i_WriteData;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
        end
    end

    // ------------------------------------------------------------------
    // Registered config write port, driven from the state being entered
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_wr_en   <= 2'b00;
            r_wr_addr <= '0;
            r_wr_data <= 8'd0;
            r_lo_byte <= 8'd0;
        end else begin
            case (w_next_state)
                S_WR_HI: begin
                    r_wr_en   <= 2'b01;
                    r_wr_addr <= r_fifo_addr[r_rd_ptr];
                    r_wr_data <= r_fifo_data[r_rd_ptr][15:8];
                    r_lo_byte <= r_fifo_data[r_rd_ptr][7:0];
                end
                S_WR_LO: begin
                    r_wr_en   <= 2'b10;
                    r_wr_data <= r_lo_byte;
                end
                default: begin
                    r_wr_en   <= 2'b00;
                end
            endcase
        end
    end

    assign o_PhaseStepConfigWriteEnable = r_wr_en;
    assign o_PhaseStepConfigWriteAddr   = r_wr_addr;
    assign o_PhaseStepConfigWriteData   = r_wr_data;
    assign o_Busy                       = (r_state != S_IDLE) || !w_empty;
    assign o_FifoCount                  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_phase_step_config_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_phase_step_config_writer
// Purpose  : Self-checking bench for phase_step_config_writer. A queue-based
//            model of the expected byte stream is compared against the DUT on
//            every cycle, alongside directed scenarios with literal values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_phase_step_config_writer;

    localparam int AW    = 6;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            valid = 1'b0;
    logic            ready;
    logic [AW-1:0]   waddr = '0;
    logic [15:0]     wdata = '0;
    logic            hold = 1'b0;
    logic [1:0]      en;
    logic [AW-1:0]   oaddr;
    logic [7:0]      odata;
    logic            busy;
    logic [CW-1:0]   count;
`ifdef PHASE_STEP_WRITER_DROP_COUNT_EN
    logic [7:0]      drop_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    phase_step_config_writer #(
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_Clock                      (clk),
        .i_Reset                      (rst),
        .i_WriteValid                 (valid),
        .o_WriteReady                 (ready),
        .i_WriteAddr                  (waddr),
        .i_WriteData                  (wdata),
        .i_WriteHold                  (hold),
        .o_PhaseStepConfigWriteEnable (en),
        .o_PhaseStepConfigWriteAddr   (oaddr),
        .o_PhaseStepConfigWriteData   (odata),
        .o_Busy                       (busy),
        .o_FifoCount                  (count)
`ifdef PHASE_STEP_WRITER_DROP_COUNT_EN
        ,
        .o_DropCount                  (drop_count)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a queue of pending words plus the number of bytes
    // of the current word still to be shown on the port (2 = high byte
    // showing, 1 = low byte showing, 0 = idle).
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [AW-1:0] a;
        logic [15:0]   d;
    } ent_t;

    ent_t m_q[$];
    ent_t m_cur;
    int   m_left  = 0;
    int   m_drops = 0;
    bit   m_valid = 1'b0;
    int   m_size;
    bit   m_start;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_left  = 0;
            m_drops = 0;
            m_cur   = '0;
            m_valid = 1'b1;
        end else begin
            m_size  = m_q.size();
            // A new word can begin only once the previous one has shown its
            // last byte (or nothing is in flight), data is queued, hold is low.
            m_start = (m_left <= 1) && (m_size > 0) && !hold;
            if (m_start) m_cur = m_q.pop_front();
            if (valid) begin
                if (m_size < DEPTH) m_q.push_back('{a: waddr, d: wdata});
                else if (m_drops < 255) m_drops++;
            end
            if (m_start)         m_left = 2;
            else if (m_left > 0) m_left = m_left - 1;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("enable", en, (m_left == 2) ? 2'b01 : (m_left == 1) ? 2'b10 : 2'b00);
            if (m_left != 0) begin
                check("addr", oaddr, m_cur.a);
                check("data", odata, (m_left == 2) ? m_cur.d[15:8] : m_cur.d[7:0]);
            end
            check("count", count, m_q.size());
            check("busy", busy, (m_left != 0) || (m_q.size() != 0));
`ifdef PHASE_STEP_WRITER_DROP_COUNT_EN
            check("ready", ready, 1'b1);
            check("drop_count", drop_count, m_drops);
`else
            check("ready", ready, m_q.size() < DEPTH);
`endif
        end
    end

    // Advance to just after the next active edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        int n = 0;
        while (busy && n < 60) begin
            step();
            n++;
        end
        check("drain_idle", busy, 1'b0);
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_ready", ready, 1'b1);
        check("rst_count", count, 0);
        check("rst_en", en, 2'b00);
        check("rst_busy", busy, 1'b0);

        // Single write: high byte one edge after acceptance, low byte after two
        valid = 1'b1; waddr = 6'd5; wdata = 16'hA1B2;
        step();
        valid = 1'b0;
        check("single_count", count, 1);
        check("single_en0", en, 2'b00);
        step();
        check("single_en1", en, 2'b01);
        check("single_addr1", oaddr, 6'd5);
        check("single_data1", odata, 8'hA1);
        step();
        check("single_en2", en, 2'b10);
        check("single_addr2", oaddr, 6'd5);
        check("single_data2", odata, 8'hB2);
        step();
        check("single_en3", en, 2'b00);
        check("single_busy3", busy, 1'b0);

        // Back-to-back writes, hold low
        for (int k = 0; k < 4; k++) begin
            valid = 1'b1; waddr = AW'(k); wdata = 16'h1111 * 16'(k + 1);
            step();
        end
        valid = 1'b0;
        drain();

        // Hold high: fill the FIFO, then present extra writes
        hold = 1'b1;
        for (int k = 0; k < 4; k++) begin
            valid = 1'b1; waddr = AW'(10 + k); wdata = 16'hC000 + 16'(k);
            step();
        end
        check("hold_full_count", count, 4);
`ifdef PHASE_STEP_WRITER_DROP_COUNT_EN
        for (int k = 0; k < 3; k++) begin
            valid = 1'b1; waddr = AW'(20 + k); wdata = 16'hDEAD;
            step();
        end
        valid = 1'b0;
        check("drop_count3", drop_count, 8'd3);
        check("drop_keep_count", count, 4);
        hold = 1'b0;
        step();
        check("drop_first_hi", odata, 8'hC0);
        check("drop_first_addr", oaddr, 6'd10);
        drain();
`else
        valid = 1'b1; waddr = 6'd14; wdata = 16'h5A5A;
        step();
        check("hold_ready_low", ready, 1'b0);
        check("hold_count4", count, 4);
        hold = 1'b0;
        step();
        check("release_en", en, 2'b01);
        check("release_count", count, 3);
        check("release_ready", ready, 1'b1);
        step();
        valid = 1'b0;
        check("fifth_accepted", count, 4);
        drain();
`endif

        // Hold raised right as WR_HI is entered: low byte still issued
        valid = 1'b1; waddr = 6'd33; wdata = 16'h1234;
        step();
        valid = 1'b0;
        step();
        hold = 1'b1;
        check("hmid_en_hi", en, 2'b01);
        valid = 1'b1; waddr = 6'd34; wdata = 16'h5678;
        step();
        valid = 1'b0;
        check("hmid_en_lo", en, 2'b10);
        check("hmid_data_lo", odata, 8'h34);
        step();
        check("hmid_stop", en, 2'b00);
        check("hmid_count", count, 1);
        step();
        check("hmid_still_stop", en, 2'b00);
        hold = 1'b0;
        step();
        check("hmid_resume", en, 2'b01);
        check("hmid_resume_data", odata, 8'h56);
        drain();

        // Reset during WR_HI with two entries queued
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            valid = 1'b1; waddr = AW'(40 + k); wdata = 16'hBEE0 + 16'(k);
            step();
        end
        valid = 1'b0;
        hold = 1'b0;
        step();
        check("prerst_en", en, 2'b01);
        check("prerst_count", count, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_en", en, 2'b00);
        check("midrst_count", count, 0);
        check("midrst_ready", ready, 1'b1);
        step();
        step();
        check("postrst_en", en, 2'b00);
        check("postrst_busy", busy, 1'b0);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            valid = ($urandom_range(0, 2) != 0);
            hold  = ($urandom_range(0, 5) == 0);
            waddr = AW'($urandom);
            wdata = 16'($urandom);
            rst   = ($urandom_range(0, 120) == 0);
            step();
        end
        rst = 1'b0; valid = 1'b0; hold = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
